// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer types and grant-controller FSM states.
package ahb_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_NONSEQ = 2'b10,
      HT_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      GS_IDLE,
      GS_OWNED,
      GS_LOCKED
   } grant_state_t;

   // BUSY and SEQ both mean the owner is mid-burst and must keep the bus.
   function automatic logic in_burst(input htrans_t t);
      return (t == HT_BUSY) || (t == HT_SEQ);
   endfunction

endpackage

// File: rtl/reversearbiter.sv
// Fixed-priority arbiter: grants the lowest-index request (LSB = highest priority).
module reversearbiter #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] gnt
);

   // Isolate the lowest set bit.
   assign gnt = req & (~req + WIDTH'(1));

endmodule

// File: rtl/ahb_grant_ctrl.sv
// Registered AHB manager grant: holds across bursts and locked sequences, re-arbitrates
// only at HREADY boundaries, and tracks the data-phase owner for the response demux.
module ahb_grant_ctrl
   import ahb_pkg::*;
#(
   parameter int NUM_MGR = 4,
   parameter int IDXW    = $clog2(NUM_MGR)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_MGR-1:0] MgrReq,
   input  logic [NUM_MGR-1:0] MgrLock,
   input  logic [1:0]         HTRANS,
   input  logic               HREADY,
   output logic [NUM_MGR-1:0] Grant,
   output logic [IDXW-1:0]    GrantIdx,
   output logic               GrantValid,
   output logic               GrantLocked,
   output logic [NUM_MGR-1:0] DataOwner,
   output logic               DataOwnerValid
);

   grant_state_t       state;
   htrans_t            ht;
   logic [NUM_MGR-1:0] cand;
   logic               owner_locked;

   reversearbiter #(.WIDTH(NUM_MGR)) u_arb (
      .req (MgrReq),
      .gnt (cand)
   );

   assign ht           = htrans_t'(HTRANS);
   assign owner_locked = |(MgrLock & Grant);
   assign GrantValid   = |Grant;
   assign GrantLocked  = (state == GS_LOCKED);

   always_comb begin
      GrantIdx = '0;
      for (int i = 0; i < NUM_MGR; i++)
         if (Grant[i]) GrantIdx = GrantIdx | IDXW'(i);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= GS_IDLE;
         Grant          <= '0;
         DataOwner      <= '0;
         DataOwnerValid <= 1'b0;
      end else begin
         // Wait-stated data phase keeps its owner; otherwise follow the accepted address phase.
         if (HREADY) begin
            if (GrantValid && HTRANS[1]) begin
               DataOwner      <= Grant;
               DataOwnerValid <= 1'b1;
            end else begin
               DataOwner      <= '0;
               DataOwnerValid <= 1'b0;
            end
         end

         case (state)
            GS_IDLE: begin
               if (|MgrReq) begin
                  Grant <= cand;
                  state <= GS_OWNED;
               end
            end
            GS_OWNED, GS_LOCKED: begin
               if (HREADY && !in_burst(ht)) begin
                  if (owner_locked && (state == GS_LOCKED || ht == HT_NONSEQ)) begin
                     state <= GS_LOCKED;
                  end else if (|cand) begin
                     Grant <= cand;
                     state <= GS_OWNED;
                  end else begin
                     Grant <= '0;
                     state <= GS_IDLE;
                  end
               end
            end
            default: begin
               Grant <= '0;
               state <= GS_IDLE;
            end
         endcase
      end
   end

endmodule
